// File: rtl/memory_pkg.sv
// memory_pkg: shared types and default widths for the lane memory arbiter
package memory_pkg;
  localparam int MEM_BLOCK_DIM = 8;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 9;
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } lane_req_pkt;
  typedef enum logic [1:0] {IDLE, SERVE, DRAIN, HOLD} arb_state_t;
endpackage

// File: rtl/lane_prio_enc.sv
// lane_prio_enc: lowest-set-bit encoder returning index and found flag
module lane_prio_enc #(
  parameter int N = 8,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);
  // scan downward so the lowest set bit is the last one written
  always_comb begin
    idx_o = '0;
    for (int j = N - 1; j >= 0; j--) if (req_i[j]) idx_o = W'(j);
  end
  assign found_o = |req_i;
endmodule

// File: rtl/lane_mem_arbiter.sv
// lane_mem_arbiter: serialises one instruction's per-lane requests onto a single-port RAM
module lane_mem_arbiter
  import memory_pkg::*;
#(
  parameter int BLOCK_DIM = MEM_BLOCK_DIM,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BLOCK_DIM-1:0]        req_valid,
  input  logic [BLOCK_DIM-1:0]        req_we,
  input  logic [BLOCK_DIM*ADDR_W-1:0] req_addr,
  input  logic [BLOCK_DIM*DATA_W-1:0] req_wdata,
  input  logic                        ext_stall,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [BLOCK_DIM*DATA_W-1:0] lane_rdata,
  output logic                        stall_out
);
  localparam int LW = BLOCK_DIM > 1 ? $clog2(BLOCK_DIM) : 1;
  arb_state_t                       state_q;
  logic [BLOCK_DIM-1:0]             pending_q, pending_d, we_q;
  logic [BLOCK_DIM-1:0][ADDR_W-1:0] addr_q;
  logic [BLOCK_DIM-1:0][DATA_W-1:0] wdata_q, rdata_q;
  logic                             rd_vld_q;
  logic [LW-1:0]                    rd_lane_q, k;
  logic                             found, serve;
  lane_prio_enc #(.N(BLOCK_DIM)) u_enc (
    .req_i  (pending_q),
    .idx_o  (k),
    .found_o(found)
  );
  assign serve = state_q == SERVE && found;
  assign pending_d = pending_q & ~(BLOCK_DIM'(1) << k);
  // memory port is decoded from latched requests so it falls with async reset
  assign mem_en = serve;
  assign mem_we = serve & we_q[k];
  assign mem_addr = serve ? addr_q[k] : '0;
  assign mem_wdata = serve ? wdata_q[k] : '0;
  assign stall_out = !rst && (state_q == SERVE || (state_q == IDLE && |req_valid));
  // read data of the lane issued last cycle bypasses the capture register
  always_comb begin
    lane_rdata = rdata_q;
    if (rd_vld_q) lane_rdata[rd_lane_q*DATA_W +: DATA_W] = mem_rdata;
  end
  // batch FSM: latch on detect, issue lowest pending lane, capture returning reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_lane_q <= '0;
    end else begin
      rd_vld_q  <= serve && !we_q[k];
      rd_lane_q <= k;
      if (rd_vld_q) rdata_q[rd_lane_q] <= mem_rdata;
      case (state_q)
        IDLE: if (|req_valid) begin
          pending_q <= req_valid;
          we_q      <= req_we;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          state_q   <= SERVE;
        end
        SERVE: begin
          pending_q <= pending_d;
          if (pending_d == '0) state_q <= DRAIN;
        end
        DRAIN: state_q <= ext_stall ? HOLD : IDLE;
        default: if (!ext_stall) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_mem_arbiter.sv
// tb_lane_mem_arbiter: directed self-checking bench for lane_mem_arbiter
module tb_lane_mem_arbiter;
  localparam int N = 8, AW = 16, DW = 9;
  logic clk = 1'b0, rst = 1'b1, ext = 1'b0;
  logic [N-1:0] rv = '0, rwe = '0;
  logic [N*AW-1:0] raddr = '0;
  logic [N*DW-1:0] rwd = '0;
  logic [N*DW-1:0] lane_rdata;
  logic mem_en, mem_we, stall_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [256];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  lane_mem_arbiter #(.BLOCK_DIM(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv),
    .req_we    (rwe),
    .req_addr  (raddr),
    .req_wdata (rwd),
    .ext_stall (ext),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .lane_rdata(lane_rdata),
    .stall_out (stall_out)
  );

  // single-port synchronous RAM, preloaded while rst is high
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem[a] <= '0;
      mem[8'h10] <= 9'd5;
      mem[8'h20] <= 9'd6;
      mem[8'h30] <= 9'd7;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setl(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rv[i] = 1'b1;
    rwe[i] = we;
    raddr[i*AW +: AW] = a;
    rwd[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return lane_rdata[i*DW +: DW];
  endfunction

  initial begin
    repeat (2) tick();
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_rdata", |lane_rdata, 0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_stall", stall_out, 0);
      chk("idle_en", mem_en, 0);
    end
    setl(1, 1'b0, 16'h10, 9'd0);
    setl(3, 1'b0, 16'h20, 9'd0);
    setl(6, 1'b0, 16'h30, 9'd0);
    #1;
    chk("rd_detect_stall", stall_out, 1);
    chk("rd_detect_en", mem_en, 0);
    tick();
    chk("rd_s1_en", mem_en, 1);
    chk("rd_s1_addr", mem_addr, 'h10);
    chk("rd_s1_stall", stall_out, 1);
    tick();
    chk("rd_s2_addr", mem_addr, 'h20);
    chk("rd_s2_stall", stall_out, 1);
    tick();
    chk("rd_s3_addr", mem_addr, 'h30);
    chk("rd_s3_stall", stall_out, 1);
    tick();
    chk("rd_drain_stall", stall_out, 0);
    chk("rd_drain_en", mem_en, 0);
    chk("rd_lane1", lane(1), 5);
    chk("rd_lane3", lane(3), 6);
    chk("rd_lane6_bypass", lane(6), 7);
    tick();
    rv = '0;
    #1;
    chk("rd_idle_stall", stall_out, 0);
    chk("rd_idle_lane6", lane(6), 7);
    for (int i = 0; i < N; i++) setl(i, 1'b1, 16'h40, DW'(i));
    #1;
    chk("wr_detect_stall", stall_out, 1);
    for (int i = 0; i < N; i++) begin
      tick();
      chk("wr_en", mem_en, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 'h40);
      chk("wr_data", mem_wdata, i);
      chk("wr_stall", stall_out, 1);
    end
    tick();
    chk("wr_drain_stall", stall_out, 0);
    chk("wr_keep_lane3", lane(3), 6);
    tick();
    rv = '0;
    rwe = '0;
    setl(0, 1'b0, 16'h40, 9'd0);
    #1;
    tick();
    chk("rb_addr", mem_addr, 'h40);
    chk("rb_we", mem_we, 0);
    tick();
    chk("rb_lane0", lane(0), 7);
    tick();
    rv = '0;
    setl(0, 1'b1, 16'h4, 9'h55);
    setl(2, 1'b0, 16'h4, 9'd0);
    #1;
    tick();
    chk("raw_s1_we", mem_we, 1);
    chk("raw_s1_addr", mem_addr, 4);
    tick();
    chk("raw_s2_we", mem_we, 0);
    chk("raw_s2_addr", mem_addr, 4);
    tick();
    chk("raw_lane2", lane(2), 'h55);
    tick();
    rv = '0;
    rwe = '0;
    ext = 1'b1;
    setl(4, 1'b0, 16'h10, 9'd0);
    setl(5, 1'b0, 16'h30, 9'd0);
    #1;
    chk("hs_detect_stall", stall_out, 1);
    tick();
    chk("hs_s1_addr", mem_addr, 'h10);
    tick();
    chk("hs_s2_addr", mem_addr, 'h30);
    chk("hs_s2_stall", stall_out, 1);
    tick();
    chk("hs_drain_stall", stall_out, 0);
    chk("hs_drain_lane5", lane(5), 7);
    chk("hs_drain_lane4", lane(4), 5);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("hold_en", mem_en, 0);
      chk("hold_stall", stall_out, 0);
      chk("hold_lane5", lane(5), 7);
      chk("hold_lane4", lane(4), 5);
    end
    ext = 1'b0;
    tick();
    rv = '0;
    #1;
    chk("hold_exit_stall", stall_out, 0);
    chk("hold_exit_en", mem_en, 0);
    tick();
    chk("post_hold_en", mem_en, 0);
    for (int i = 0; i < N; i++) setl(i, 1'b0, AW'(16'h40 + i), 9'd0);
    #1;
    tick();
    chk("rs_s1_addr", mem_addr, 'h40);
    tick();
    chk("rs_s2_addr", mem_addr, 'h41);
    rst = 1'b1;
    #1;
    chk("rs_en", mem_en, 0);
    chk("rs_stall", stall_out, 0);
    chk("rs_rdata", |lane_rdata, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rs_detect", stall_out, 1);
    tick();
    chk("rs_restart_en", mem_en, 1);
    chk("rs_restart_addr", mem_addr, 'h40);
    tick();
    chk("rs_next_addr", mem_addr, 'h41);
    rv = '0;
    rst = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_mem_arbiter.md
Name: lane_mem_arbiter

Overview:
Serialises the per-lane memory requests of one SIMD instruction onto a single-port synchronous data memory. Sits between the BLOCK_DIM simd_lane instances and the data RAM. Freezes the fetch/decode/lane pipeline with `stall_out` while it works through the batch. Returns per-lane read data so that it is valid in the cycle the pipeline is released.

Parameters:
BLOCK_DIM, 8, number of lanes (requesters)
ADDR_W, 16, memory word address width
DATA_W, 9, memory data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  BLOCK_DIM  per-lane access request, held stable while stall_out=1
req_we  in  BLOCK_DIM  per-lane write (1) / read (0)
req_addr  in  BLOCK_DIM*ADDR_W  per-lane address, lane i at [i*ADDR_W +: ADDR_W]
req_wdata  in  BLOCK_DIM*DATA_W  per-lane write data
ext_stall  in  1  pipeline stall from other sources (e.g. ~vdma_ready)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0
lane_rdata  out  BLOCK_DIM*DATA_W  per-lane read result
stall_out  out  1  pipeline freeze request

Behaviour:
- States: IDLE, SERVE, DRAIN, HOLD. Reset leads to IDLE.
- Reset clears pending mask, latched requests, rdata_q and the last-read tracker. Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, lane_rdata=0, stall_out=0.
- Reset mid-operation aborts the batch. No further memory strobes are issued.
- IDLE:
  - If no bit of req_valid is set: stall_out=0 and the state does not change.
  - If any bit is set:
    - stall_out=1 combinationally in the same cycle.
    - At the clock edge, latch pending=req_valid plus all req_we/addr/wdata, then go to SERVE.
- SERVE:
  - Each cycle, issue the lowest-index pending lane k.
  - Drive mem_en=1, mem_we=we[k], mem_addr=addr[k], mem_wdata=wdata[k] (registered outputs, or combinational from latched state; must be valid in the SERVE cycle).
  - Clear bit k of pending.
  - When pending becomes empty, go to DRAIN.
  - stall_out=1 throughout SERVE.
- Ordering: ascending lane index within a batch.
  - For same-address writes, the highest lane wins.
  - A read sees writes from lower lanes of the same batch.
- Read return: mem_rdata captured into rdata_q[k] one cycle after the issue of read lane k. Write lanes keep their previous rdata_q.
- lane_rdata[i] = mem_rdata when i is the read lane issued in the previous cycle (bypass), else rdata_q[i].
- DRAIN:
  - stall_out=0 and mem_en=0. Final read captured this cycle, with bypass active.
  - If ext_stall=0, go to IDLE; the pipeline advances on this edge.
  - If ext_stall=1, go to HOLD.
- HOLD:
  - stall_out=0, no memory access. lane_rdata comes from rdata_q.
  - Requests of the current instruction are still presented and must NOT be re-captured.
  - Go to IDLE when ext_stall=0.
- Timing: for N requesting lanes, stall_out is high for N+1 cycles (detect + N issue). With ext_stall low, the pipeline moves at the end of cycle N+1.
- ext_stall has no effect in IDLE/SERVE: the batch proceeds regardless, and stall_out keeps the pipeline frozen.
- req_* changing while stall_out=1 is a protocol violation. Latched copies are used, so it is harmless.
- A single-lane request takes IDLE→SERVE→DRAIN (2 stall cycles).

Decomposition:
- Shared package memory_pkg holds:
  - a lane_req_pkt typedef (valid, we, addr, wdata);
  - ADDR_W/DATA_W defaults;
  - an arb_state_t enum.
- One sub-module is natural: lane_prio_enc, a parameterised lowest-set-bit encoder returning index + found flag.

Test Plan:
- No requests, 10 cycles: stall_out=0 and mem_en=0 throughout.
- Lanes 1,3,6 read addr 0x10,0x20,0x30, mem preloaded 5,6,7:
  - stall_out high 4 cycles;
  - mem_addr sequence 0x10,0x20,0x30;
  - in DRAIN, lane_rdata[1]=5, [3]=6, [6]=7 (lane 6 via bypass).
- All 8 lanes write addr 0x40, data = lane index:
  - 8 issue cycles;
  - a subsequent single read of 0x40 returns 7.
- Lane 0 writes 0x55 to addr 4 and lane 2 reads addr 4 in the same batch: lane_rdata[2]=0x55.
- ext_stall=1 on entering DRAIN, held 3 cycles:
  - state goes to HOLD;
  - no re-capture and no mem_en;
  - lane_rdata stable;
  - IDLE after ext_stall falls.
- rst asserted in the middle of an 8-lane batch (2nd issue cycle):
  - mem_en drops asynchronously and stall_out=0;
  - after release with requests present, a fresh batch starts from lane 0.
